// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among NUM_REQ result producers.
// Ports: clk_in/rst_in/rdy_in/flush_signal control; req_valid/req_rob/
// req_data in, req_ready grant out; cdb_valid/cdb_rob/cdb_data/cdb_src
// registered broadcast. Macro CDB_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of the default round-robin.
module cdb_arbiter #(
  parameter int RoB_WIDTH = 3,
  parameter int NUM_REQ   = 3,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_signal,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*RoB_WIDTH-1:0] req_rob,
  input  logic [NUM_REQ*32-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [RoB_WIDTH-1:0]         cdb_rob,
  output logic [31:0]                  cdb_data,
  output logic [SRC_W-1:0]             cdb_src
);

  logic                 cdb_valid_q;
  logic [RoB_WIDTH-1:0] cdb_rob_q;
  logic [31:0]          cdb_data_q;
  logic [SRC_W-1:0]     cdb_src_q;

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [SRC_W-1:0]     last_ptr_q;
`endif

  logic                 en;
  logic                 found;
  logic [SRC_W-1:0]     win;
  logic [SRC_W-1:0]     idx;
  logic [RoB_WIDTH-1:0] win_rob;
  logic [31:0]          win_data;

  assign en = rdy_in && !flush_signal && !rst_in;

  // Scan order: from the slot after the last winner (round-robin) or
  // from slot 0 (fixed priority); the first valid slot wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
      idx = SRC_W'(k);
`else
      idx = SRC_W'((int'(last_ptr_q) + 1 + k) % NUM_REQ);
`endif
      if (en && !found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = found && (win == SRC_W'(i));
    end
  end

  always_comb begin
    win_rob  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win_rob  = req_rob[i*RoB_WIDTH +: RoB_WIDTH];
        win_data = req_data[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      last_ptr_q  <= SRC_W'(NUM_REQ - 1);
`endif
    end else if (rdy_in) begin
      if (flush_signal) begin
        cdb_valid_q <= 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
        last_ptr_q  <= SRC_W'(NUM_REQ - 1);
`endif
      end else if (found) begin
        cdb_valid_q <= 1'b1;
        cdb_rob_q   <= win_rob;
        cdb_data_q  <= win_data;
        cdb_src_q   <= win;
`ifndef CDB_ARB_FIXED_PRIO_EN
        last_ptr_q  <= win;
`endif
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized stimulus against a behavioural model of the
// CDB arbiter (round-robin, or fixed priority with CDB_ARB_FIXED_PRIO_EN).
module tb_cdb_arbiter;

  localparam int RW  = 3;
  localparam int NUM = 3;
  localparam int SW  = $clog2(NUM);
  localparam int CYC = 2400;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                rdy_in;
  logic                flush_signal;
  logic [NUM-1:0]      req_valid;
  logic [NUM*RW-1:0]   req_rob;
  logic [NUM*32-1:0]   req_data;
  logic [NUM-1:0]      req_ready;
  logic                cdb_valid;
  logic [RW-1:0]       cdb_rob;
  logic [31:0]         cdb_data;
  logic [SW-1:0]       cdb_src;

  cdb_arbiter #(
    .RoB_WIDTH (RW),
    .NUM_REQ   (NUM)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_signal (flush_signal),
    .req_valid    (req_valid),
    .req_rob      (req_rob),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cdb_valid    (cdb_valid),
    .cdb_rob      (cdb_rob),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  // requester-side state
  bit          vld [NUM];
  logic [RW-1:0] rob [NUM];
  logic [31:0] dat [NUM];

  // model state
  int          ptr;
  bit          e_valid;
  int          e_rob;
  int          e_data;
  int          e_src;
  int          g;

  int n_chk;
  int n_err;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst_in || !rdy_in || flush_signal) return -1;
    for (int k = 1; k <= NUM; k++) begin
      int j;
      j = (ptr + k) % NUM;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst_in) begin
      e_valid = 0;
      e_rob   = 0;
      e_data  = 0;
      e_src   = 0;
      ptr     = NUM - 1;
    end else if (rdy_in) begin
      if (flush_signal) begin
        e_valid = 0;
        ptr     = NUM - 1;
      end else if (g >= 0) begin
        e_valid = 1;
        e_rob   = int'(rob[g]);
        e_data  = int'(dat[g]);
        e_src   = g;
`ifndef CDB_ARB_FIXED_PRIO_EN
        ptr     = g;
`endif
      end else begin
        e_valid = 0;
      end
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NUM; i++) begin
      req_valid[i]          = vld[i];
      req_rob[i*RW +: RW]   = rob[i];
      req_data[i*32 +: 32]  = dat[i];
    end
  endtask

  initial begin
    int mode;
    int p;
    int sel;
    logic [NUM-1:0] e_rdy;
    n_chk = 0;
    n_err = 0;
    ptr   = NUM - 1;
    g     = -1;
    e_valid = 0;
    e_rob = 0;
    e_data = 0;
    e_src = 0;
    for (int i = 0; i < NUM; i++) begin
      vld[i] = 0;
      rob[i] = '0;
      dat[i] = '0;
    end
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    flush_signal = 1'b0;
    pack();

    for (int cyc = 0; cyc < CYC; cyc++) begin
      @(negedge clk_in);
      model_step();
      check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      check("cdb_rob",   64'(cdb_rob),   64'(e_rob));
      check("cdb_data",  64'(cdb_data),  64'(unsigned'(e_data)));
      check("cdb_src",   64'(cdb_src),   64'(e_src));

      // accepted requester retires; it may post a fresh result below
      if (g >= 0) vld[g] = 0;

      mode = (cyc / 300) % 4;
      sel  = (cyc / 300) % NUM;
      for (int i = 0; i < NUM; i++) begin
        unique case (mode)
          1:       p = 100;
          2:       p = (i == sel) ? 100 : 0;
          default: p = 50;
        endcase
        if (!vld[i] && ($urandom_range(99) < p)) begin
          vld[i] = 1;
          rob[i] = RW'($urandom);
          dat[i] = $urandom;
        end
      end

      if (cyc < 2) begin
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        flush_signal = 1'b0;
      end else if (mode == 1 || mode == 2) begin
        rst_in       = 1'b0;
        rdy_in       = ($urandom_range(99) >= 5);
        flush_signal = ($urandom_range(99) < 2);
      end else begin
        rst_in       = ($urandom_range(99) < 2);
        rdy_in       = ($urandom_range(99) >= 15);
        flush_signal = ($urandom_range(99) < 6);
      end
      pack();
      #1;
      g = model_grant();
      e_rdy = (g >= 0) ? NUM'(1 << g) : '0;
      check("req_ready", 64'(req_ready), 64'(e_rdy));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
